// File: rtl/ppu_vram_responder_if.sv
// Bundle of the pixel-pipeline, sprite-flag, CPU and BRAM signals served by
// ppu_vram_responder. The slave modport is the responder's view and the
// master modport is the view of everything around it.
//
// Handshake semantics: every request (addr_valid_in, flag_request_in,
// cpu_rd_in/cpu_wr_in) is level-held with a stable address until its one-cycle
// response pulse (data_valid_out, valid_flags_out, cpu_ack_out) and is dropped
// in the following cycle. A request still high once the channel is idle again
// counts as a new request.
interface ppu_vram_responder_if;
  logic [15:0] addr_in;
  logic        addr_valid_in;
  logic [7:0]  data_out;
  logic        data_valid_out;
  logic [15:0] flag_addr_in;
  logic        flag_request_in;
  logic [7:0]  sprite_flags_out;
  logic        valid_flags_out;
  logic [15:0] cpu_addr_in;
  logic        cpu_rd_in;
  logic        cpu_wr_in;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic        cpu_ack_out;
  logic [1:0]  ppu_mode_in;
  logic        lcd_on_in;
  logic [12:0] vram_addr_out;
  logic        vram_we_out;
  logic [7:0]  vram_din_out;
  logic [7:0]  vram_dout_in;
  logic [7:0]  oam_addr_out;
  logic        oam_we_out;
  logic [7:0]  oam_din_out;
  logic [7:0]  oam_dout_in;
  logic [1:0]  vram_state_dbg;
  logic [1:0]  oam_state_dbg;

  modport slave (
    input  addr_in, addr_valid_in, flag_addr_in, flag_request_in,
    input  cpu_addr_in, cpu_rd_in, cpu_wr_in, cpu_data_in,
    input  ppu_mode_in, lcd_on_in, vram_dout_in, oam_dout_in,
    output data_out, data_valid_out, sprite_flags_out, valid_flags_out,
    output cpu_data_out, cpu_ack_out,
    output vram_addr_out, vram_we_out, vram_din_out,
    output oam_addr_out, oam_we_out, oam_din_out,
    output vram_state_dbg, oam_state_dbg
  );

  modport master (
    output addr_in, addr_valid_in, flag_addr_in, flag_request_in,
    output cpu_addr_in, cpu_rd_in, cpu_wr_in, cpu_data_in,
    output ppu_mode_in, lcd_on_in, vram_dout_in, oam_dout_in,
    input  data_out, data_valid_out, sprite_flags_out, valid_flags_out,
    input  cpu_data_out, cpu_ack_out,
    input  vram_addr_out, vram_we_out, vram_din_out,
    input  oam_addr_out, oam_we_out, oam_din_out,
    input  vram_state_dbg, oam_state_dbg
  );
endinterface

// File: rtl/ppu_vram_responder.sv
// VRAM/OAM responder: two independent single-outstanding channels, each the
// sole owner of one single-port BRAM, arbitrating a PPU requester against the
// CPU with DMG-style mode blocking.

// One BRAM channel. PPU request wins over CPU in IDLE. Accesses that must not
// touch the BRAM (out of range, blocked, unmapped) bypass it but keep the
// normal response timing: PPU reads still pulse at A+2+READ_LATENCY, CPU
// bypasses ack at A+1 through the WRITE state.
module ppu_vram_responder_chan #(
  parameter int AW           = 13,
  parameter int READ_LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ppu_req,
  input  logic          ppu_hit,
  input  logic [AW-1:0] ppu_idx,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic          cpu_hit,
  input  logic          cpu_blocked,
  input  logic [AW-1:0] cpu_idx,
  input  logic [7:0]    cpu_wdata,
  input  logic [7:0]    bram_dout,
  output logic [AW-1:0] bram_addr,
  output logic          bram_we,
  output logic [7:0]    bram_din,
  output logic [7:0]    ppu_data,
  output logic          ppu_valid,
  output logic [7:0]    cpu_data,
  output logic          cpu_ack,
  output logic          cpu_dvalid,
  output logic [1:0]    state_dbg
);
  localparam int CW = $clog2(READ_LATENCY + 2);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, RESP = 2'd2, WRITE = 2'd3} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner_cpu;
  logic          use_bram;
  logic [7:0]    rd_value;

  assign state_dbg = state;
  assign rd_value  = use_bram ? bram_dout : 8'hFF;

  // Channel FSM with registered BRAM controls and response pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      owner_cpu  <= 1'b0;
      use_bram   <= 1'b0;
      bram_addr  <= '0;
      bram_we    <= 1'b0;
      bram_din   <= 8'h00;
      ppu_data   <= 8'h00;
      ppu_valid  <= 1'b0;
      cpu_data   <= 8'h00;
      cpu_ack    <= 1'b0;
      cpu_dvalid <= 1'b0;
    end else begin
      bram_we    <= 1'b0;
      ppu_valid  <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_dvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (ppu_req) begin
            owner_cpu <= 1'b0;
            use_bram  <= ppu_hit;
            if (ppu_hit) bram_addr <= ppu_idx;
            cnt   <= '0;
            state <= READ;
          end else if (cpu_req) begin
            owner_cpu <= 1'b1;
            if (cpu_wr) begin
              // Blocked or unmapped writes are acked and dropped.
              if (cpu_hit && !cpu_blocked) begin
                bram_addr <= cpu_idx;
                bram_din  <= cpu_wdata;
                bram_we   <= 1'b1;
              end
              cpu_ack <= 1'b1;
              state   <= WRITE;
            end else if (cpu_hit && !cpu_blocked) begin
              use_bram  <= 1'b1;
              bram_addr <= cpu_idx;
              cnt       <= '0;
              state     <= READ;
            end else begin
              cpu_data   <= 8'hFF;
              cpu_ack    <= 1'b1;
              cpu_dvalid <= 1'b1;
              state      <= WRITE;
            end
          end
        end
        READ: begin
          if (cnt == CW'(READ_LATENCY)) begin
            if (owner_cpu) begin
              cpu_data   <= rd_value;
              cpu_ack    <= 1'b1;
              cpu_dvalid <= 1'b1;
            end else begin
              ppu_data  <= rd_value;
              ppu_valid <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module ppu_vram_responder #(
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  ppu_vram_responder_if.slave  bus
);
  logic       pix_in_vram, flag_in_oam, cpu_in_vram, cpu_in_oam;
  logic       cpu_req, vram_blocked, oam_blocked;
  logic [7:0] v_cpu_data, o_cpu_data;
  logic       v_cpu_ack, o_cpu_ack, v_cpu_dvalid, o_cpu_dvalid;
  logic [7:0] cpu_data_hold, cpu_data_next;

  assign pix_in_vram  = (bus.addr_in[15:13] == 3'b100);
  assign flag_in_oam  = (bus.flag_addr_in[15:8] == 8'hFE) && (bus.flag_addr_in[7:0] < 8'hA0);
  assign cpu_in_vram  = (bus.cpu_addr_in[15:13] == 3'b100);
  assign cpu_in_oam   = (bus.cpu_addr_in[15:8] == 8'hFE) && (bus.cpu_addr_in[7:0] < 8'hA0);
  assign cpu_req      = bus.cpu_rd_in | bus.cpu_wr_in;
  assign vram_blocked = bus.lcd_on_in && (bus.ppu_mode_in == 2'd3);
  assign oam_blocked  = bus.lcd_on_in && bus.ppu_mode_in[1];

  // The VRAM channel also owns CPU accesses that decode to neither BRAM;
  // with cpu_hit low they take the 1-cycle bypass ack.
  ppu_vram_responder_chan #(.AW(13), .READ_LATENCY(READ_LATENCY)) u_vram (
    .clk         (clk_in),
    .rst_n       (rst_in),
    .ppu_req     (bus.addr_valid_in),
    .ppu_hit     (pix_in_vram),
    .ppu_idx     (bus.addr_in[12:0]),
    .cpu_req     (cpu_req && !cpu_in_oam),
    .cpu_wr      (bus.cpu_wr_in),
    .cpu_hit     (cpu_in_vram),
    .cpu_blocked (vram_blocked),
    .cpu_idx     (bus.cpu_addr_in[12:0]),
    .cpu_wdata   (bus.cpu_data_in),
    .bram_dout   (bus.vram_dout_in),
    .bram_addr   (bus.vram_addr_out),
    .bram_we     (bus.vram_we_out),
    .bram_din    (bus.vram_din_out),
    .ppu_data    (bus.data_out),
    .ppu_valid   (bus.data_valid_out),
    .cpu_data    (v_cpu_data),
    .cpu_ack     (v_cpu_ack),
    .cpu_dvalid  (v_cpu_dvalid),
    .state_dbg   (bus.vram_state_dbg)
  );

  ppu_vram_responder_chan #(.AW(8), .READ_LATENCY(READ_LATENCY)) u_oam (
    .clk         (clk_in),
    .rst_n       (rst_in),
    .ppu_req     (bus.flag_request_in),
    .ppu_hit     (flag_in_oam),
    .ppu_idx     (bus.flag_addr_in[7:0]),
    .cpu_req     (cpu_req && cpu_in_oam),
    .cpu_wr      (bus.cpu_wr_in),
    .cpu_hit     (1'b1),
    .cpu_blocked (oam_blocked),
    .cpu_idx     (bus.cpu_addr_in[7:0]),
    .cpu_wdata   (bus.cpu_data_in),
    .bram_dout   (bus.oam_dout_in),
    .bram_addr   (bus.oam_addr_out),
    .bram_we     (bus.oam_we_out),
    .bram_din    (bus.oam_din_out),
    .ppu_data    (bus.sprite_flags_out),
    .ppu_valid   (bus.valid_flags_out),
    .cpu_data    (o_cpu_data),
    .cpu_ack     (o_cpu_ack),
    .cpu_dvalid  (o_cpu_dvalid),
    .state_dbg   (bus.oam_state_dbg)
  );

  // Only one CPU access is ever in flight, so the acking channel owns the
  // CPU data bus for that cycle; otherwise the last delivered value is held.
  always_comb begin
    cpu_data_next = cpu_data_hold;
    if (v_cpu_dvalid)      cpu_data_next = v_cpu_data;
    else if (o_cpu_dvalid) cpu_data_next = o_cpu_data;
  end

  // Remember the last CPU read value shown on cpu_data_out.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) cpu_data_hold <= 8'h00;
    else         cpu_data_hold <= cpu_data_next;
  end

  assign bus.cpu_data_out = cpu_data_next;
  assign bus.cpu_ack_out  = v_cpu_ack | o_cpu_ack;
endmodule

// File: tb/tb_ppu_vram_responder.sv
// Directed bench for ppu_vram_responder with behavioural VRAM/OAM BRAMs
// (2-cycle read latency from the registered address).
module tb_ppu_vram_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ppu_vram_responder_if bus();

  ppu_vram_responder #(.READ_LATENCY(2)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // BRAM models with a backdoor preload port
  logic [7:0]  vram_mem [0:8191];
  logic [7:0]  oam_mem  [0:255];
  logic [7:0]  v_s1 = 8'h00, v_s2 = 8'h00, o_s1 = 8'h00, o_s2 = 8'h00;
  logic        vpoke_en = 1'b0, opoke_en = 1'b0;
  logic [12:0] vpoke_a = '0;
  logic [7:0]  opoke_a = '0;
  logic [7:0]  poke_d = '0;
  int          vram_we_cnt = 0;
  int          oam_we_cnt = 0;

  always @(posedge clk) begin
    if (vpoke_en) vram_mem[vpoke_a] <= poke_d;
    else if (bus.vram_we_out) vram_mem[bus.vram_addr_out] <= bus.vram_din_out;
    v_s1 <= vram_mem[bus.vram_addr_out];
    v_s2 <= v_s1;
    if (opoke_en) oam_mem[opoke_a] <= poke_d;
    else if (bus.oam_we_out) oam_mem[bus.oam_addr_out] <= bus.oam_din_out;
    o_s1 <= oam_mem[bus.oam_addr_out];
    o_s2 <= o_s1;
    if (bus.vram_we_out) vram_we_cnt <= vram_we_cnt + 1;
    if (bus.oam_we_out)  oam_we_cnt  <= oam_we_cnt + 1;
  end

  assign bus.vram_dout_in = v_s2;
  assign bus.oam_dout_in  = o_s2;

  // scoreboard counters and transaction capture
  int         n_checks = 0;
  int         n_pass = 0;
  int         t_pix, t_flag, t_cpu;
  logic [7:0] d_pix, d_flag, d_cpu;
  logic       ack_we;
  logic [12:0] ack_addr;
  logic [7:0] ack_din;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic poke_vram(input logic [12:0] a, input logic [7:0] d);
    vpoke_en = 1'b1; vpoke_a = a; poke_d = d;
    step();
    vpoke_en = 1'b0;
  endtask

  task automatic poke_oam(input logic [7:0] a, input logic [7:0] d);
    opoke_en = 1'b1; opoke_a = a; poke_d = d;
    step();
    opoke_en = 1'b0;
  endtask

  // Called in acceptance cycle A with requests already raised. Records the
  // cycle offset (relative to A) of each response pulse and drops each
  // request as soon as its pulse is seen; -1 means no pulse within budget.
  task automatic run_txn(input int budget);
    t_pix = -1; t_flag = -1; t_cpu = -1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      step();
      if (bus.data_valid_out && t_pix < 0) begin
        t_pix = cyc; d_pix = bus.data_out; bus.addr_valid_in = 1'b0;
      end
      if (bus.valid_flags_out && t_flag < 0) begin
        t_flag = cyc; d_flag = bus.sprite_flags_out; bus.flag_request_in = 1'b0;
      end
      if (bus.cpu_ack_out && t_cpu < 0) begin
        t_cpu = cyc; d_cpu = bus.cpu_data_out;
        ack_we = bus.vram_we_out; ack_addr = bus.vram_addr_out; ack_din = bus.vram_din_out;
        bus.cpu_rd_in = 1'b0; bus.cpu_wr_in = 1'b0;
      end
      if (!bus.addr_valid_in && !bus.flag_request_in && !bus.cpu_rd_in && !bus.cpu_wr_in) break;
    end
    bus.addr_valid_in = 1'b0; bus.flag_request_in = 1'b0;
    bus.cpu_rd_in = 1'b0; bus.cpu_wr_in = 1'b0;
  endtask

  int we_before, pulses;
  logic [7:0] oam_addr_before;

  initial begin
    bus.addr_in = 16'h0; bus.addr_valid_in = 1'b0;
    bus.flag_addr_in = 16'h0; bus.flag_request_in = 1'b0;
    bus.cpu_addr_in = 16'h0; bus.cpu_rd_in = 1'b0; bus.cpu_wr_in = 1'b0;
    bus.cpu_data_in = 8'h00; bus.ppu_mode_in = 2'd0; bus.lcd_on_in = 1'b1;

    // preload memories while held in reset
    poke_vram(13'h1800, 8'h5A);
    poke_vram(13'h0010, 8'h3C);
    poke_vram(13'h0000, 8'h11);
    poke_vram(13'h0123, 8'h42);
    poke_oam(8'h04, 8'h77);
    poke_oam(8'h9F, 8'hA5);

    check("reset data_out", bus.data_out, 8'h00);
    check("reset cpu_ack", bus.cpu_ack_out, 1'b0);
    check("reset vram_state", bus.vram_state_dbg, 2'd0);
    rst_n = 1'b1;
    idle(2);

    // pixel read at 0x9800
    bus.addr_in = 16'h9800; bus.addr_valid_in = 1'b1;
    run_txn(20);
    check("pix latency", t_pix, 4);
    check("pix data", d_pix, 8'h5A);
    step();
    check("vram idle after pulse", bus.vram_state_dbg, 2'd0);
    idle(1);

    // pixel and CPU read at 0x8010 together: pixel first
    bus.addr_in = 16'h8010; bus.addr_valid_in = 1'b1;
    bus.cpu_addr_in = 16'h8010; bus.cpu_rd_in = 1'b1;
    run_txn(30);
    check("arb pix latency", t_pix, 4);
    check("arb pix data", d_pix, 8'h3C);
    check("arb cpu latency", t_cpu, 9);
    check("arb cpu data", d_cpu, 8'h3C);
    idle(2);

    // CPU write in mode 3 is blocked
    bus.ppu_mode_in = 2'd3; bus.lcd_on_in = 1'b1;
    we_before = vram_we_cnt;
    bus.cpu_addr_in = 16'h8000; bus.cpu_data_in = 8'hC3; bus.cpu_wr_in = 1'b1;
    run_txn(10);
    idle(2);
    check("blk wr ack", t_cpu, 1);
    check("blk wr no we", vram_we_cnt - we_before, 0);
    check("blk wr mem", vram_mem[0], 8'h11);

    // same write in mode 0 goes through
    bus.ppu_mode_in = 2'd0;
    we_before = vram_we_cnt;
    bus.cpu_addr_in = 16'h8000; bus.cpu_data_in = 8'hC3; bus.cpu_wr_in = 1'b1;
    run_txn(10);
    idle(2);
    check("wr ack", t_cpu, 1);
    check("wr we at ack", ack_we, 1'b1);
    check("wr addr", ack_addr, 13'h0000);
    check("wr din", ack_din, 8'hC3);
    check("wr we count", vram_we_cnt - we_before, 1);
    check("wr mem", vram_mem[0], 8'hC3);

    // CPU read of OAM in mode 2: blocked with LCD on, served with LCD off
    bus.ppu_mode_in = 2'd2; bus.lcd_on_in = 1'b1;
    bus.cpu_addr_in = 16'hFE04; bus.cpu_rd_in = 1'b1;
    run_txn(10);
    idle(2);
    check("oam blk ack", t_cpu, 1);
    check("oam blk data", d_cpu, 8'hFF);
    bus.lcd_on_in = 1'b0;
    bus.cpu_addr_in = 16'hFE04; bus.cpu_rd_in = 1'b1;
    run_txn(10);
    idle(2);
    check("oam rd ack", t_cpu, 4);
    check("oam rd data", d_cpu, 8'h77);
    bus.lcd_on_in = 1'b1; bus.ppu_mode_in = 2'd0;

    // flag and pixel together: both pulse in the same cycle
    bus.flag_addr_in = 16'hFE9F; bus.flag_request_in = 1'b1;
    bus.addr_in = 16'h8123; bus.addr_valid_in = 1'b1;
    run_txn(20);
    idle(2);
    check("dual pix latency", t_pix, 4);
    check("dual flag latency", t_flag, 4);
    check("dual pix data", d_pix, 8'h42);
    check("dual flag data", d_flag, 8'hA5);

    // flag request just past OAM: 0xFF, no OAM access
    oam_addr_before = bus.oam_addr_out;
    we_before = oam_we_cnt;
    bus.flag_addr_in = 16'hFEA0; bus.flag_request_in = 1'b1;
    run_txn(20);
    check("oor flag latency", t_flag, 4);
    check("oor flag data", d_flag, 8'hFF);
    check("oor oam addr", oam_addr_before, 8'h9F);
    check("oor oam addr kept", bus.oam_addr_out, 8'h9F);
    check("oor oam no we", oam_we_cnt - we_before, 0);
    idle(2);

    // pixel outside VRAM and unmapped CPU read
    bus.addr_in = 16'hC000; bus.addr_valid_in = 1'b1;
    run_txn(20);
    idle(2);
    check("oor pix latency", t_pix, 4);
    check("oor pix data", d_pix, 8'hFF);
    bus.cpu_addr_in = 16'hC000; bus.cpu_rd_in = 1'b1;
    run_txn(10);
    idle(2);
    check("unmapped ack", t_cpu, 1);
    check("unmapped data", d_cpu, 8'hFF);

    // reset during READ discards the access; held request is reaccepted
    bus.addr_in = 16'h9800; bus.addr_valid_in = 1'b1;
    idle(2);
    check("pre-reset in READ", bus.vram_state_dbg, 2'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset data_out", bus.data_out, 8'h00);
    check("mid reset cpu_data", bus.cpu_data_out, 8'h00);
    check("mid reset vram_addr", bus.vram_addr_out, 13'h0000);
    check("mid reset state", bus.vram_state_dbg, 2'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.data_valid_out) pulses++;
    end
    check("no pulse in reset", pulses, 0);
    rst_n = 1'b1;
    run_txn(20);
    check("post reset latency", t_pix, 4);
    check("post reset data", d_pix, 8'h5A);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
